reg_file_nrw: RTL

//   Parametrised MIPS register file: DEPTH words of WIDTH bits, NRD async read ports, one sync write port.
//   Per-byte write enables; register 0 optionally hardwired to zero.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/reg_file_nrw_if.sv | 16 +
 rtl/reg_word.sv | 19 +
 rtl/reg_file_nrw.sv | 48 ++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, word/address types and MIPS register names for the register file.
package regfile_pkg;
    localparam int REG_W     = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = 5;
    localparam int REG_ZERO  = 0;
    localparam int REG_RA    = 31;
    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]  reg_word_t;
endpackage

// File: rtl/reg_file_nrw_if.sv
// reg_file_nrw_if: write port plus packed multi-port read bus of the register file.
interface reg_file_nrw_if #(
    parameter int WIDTH = regfile_pkg::REG_W,
    parameter int DEPTH = regfile_pkg::REG_DEPTH,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(DEPTH);
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [WIDTH/8-1:0]   wbe;
    logic [WIDTH-1:0]     wdata;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*WIDTH-1:0] rdata;
    modport master (output we, waddr, wbe, wdata, raddr, input rdata);
    modport slave  (input we, waddr, wbe, wdata, raddr, output rdata);
endinterface

// File: rtl/reg_word.sv
// reg_word: one register built from per-byte enable flops with async active-high reset.
module reg_word import regfile_pkg::*; #(
    parameter int WIDTH = REG_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [WIDTH-1:0]   d,
    output logic [WIDTH-1:0]   q
);
    for (genvar b = 0; b < WIDTH / 8; b++) begin : g_byte
        logic [7:0] byte_q;
        always_ff @(posedge clk or posedge reset)
            if (reset) byte_q <= '0;
            else if (we && be[b]) byte_q <= d[8*b +: 8];
        assign q[8*b +: 8] = byte_q;
    end
endmodule

// File: rtl/reg_file_nrw.sv
// reg_file_nrw: DEPTH x WIDTH register file, NRD async read ports, one byte-enabled sync write port.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_nrw import regfile_pkg::*; #(
    parameter int WIDTH     = REG_W,
    parameter int DEPTH     = REG_DEPTH,
    parameter int NRD       = 2,
    parameter int ZERO_REG0 = 1
) (
    input logic           clk,
    input logic           reset,
    reg_file_nrw_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    for (genvar r = 0; r < DEPTH; r++) begin : g_word
        if (ZERO_REG0 != 0 && r == REG_ZERO) begin : g_zero
            assign mem[r] = '0;
        end else begin : g_reg
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .reset (reset),
                .we    (bus.we && bus.waddr == AW'(r)),
                .be    (bus.wbe),
                .d     (bus.wdata),
                .q     (mem[r])
            );
        end
    end
`ifdef REGFILE_BYPASS_EN
    logic [WIDTH-1:0] be_mask;
    logic             wr_live;
    for (genvar b = 0; b < WIDTH / 8; b++) begin : g_mask
        assign be_mask[8*b +: 8] = {8{bus.wbe[b]}};
    end
    // A write that will actually land; writes to a hardwired zero register never forward.
    assign wr_live = bus.we && |bus.wbe && !(ZERO_REG0 != 0 && bus.waddr == AW'(REG_ZERO));
`endif
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = bus.raddr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign bus.rdata[p*WIDTH +: WIDTH] = (wr_live && ra == bus.waddr)
            ? (bus.wdata & be_mask) | (mem[ra] & ~be_mask) : mem[ra];
`else
        assign bus.rdata[p*WIDTH +: WIDTH] = mem[ra];
`endif
    end
endmodule
